// File: rtl/typing_checker.sv
// rtl/typing_checker.sv - PS/2 make-code checker for the speed-typer game
// Optional: define ERROR_LIMIT_EN to end the game once error_count reaches MAX_ERRORS.
module typing_checker #(
  parameter int unsigned LOAD_WAIT_CYCLES = 4,
  parameter logic [7:0]  MAX_ERRORS       = 8'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic [7:0] comparison_data,
  input  logic [7:0] num_char,
  output logic       get_next_character,
  output logic       enable_next_level,
  output logic [7:0] char_count,
  output logic [7:0] error_count,
  output logic       correct_pulse,
  output logic       wrong_pulse,
  output logic       level_done,
  output logic       game_over
);

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] LSHIFT     = 8'h12;
  localparam logic [7:0] RSHIFT     = 8'h59;

  // The counter runs LOAD_WAIT_CYCLES-1 down to 0, so LOAD lasts LOAD_WAIT_CYCLES cycles.
  localparam int unsigned WAIT_W = $clog2(LOAD_WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LOAD_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, TYPING, BREAK, EXT, ADVANCE, DONE, FAIL
  } state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [7:0]        target, target_n;
  logic [7:0]        char_n, err_n;
  logic              get_n, enable_n, correct_n, wrong_n, done_n, over_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      target             <= 8'd0;
      char_count         <= 8'd0;
      error_count        <= 8'd0;
      get_next_character <= 1'b0;
      enable_next_level  <= 1'b0;
      correct_pulse      <= 1'b0;
      wrong_pulse        <= 1'b0;
      level_done         <= 1'b0;
      game_over          <= 1'b0;
    end else begin
      state              <= state_n;
      wait_cnt           <= wait_n;
      target             <= target_n;
      char_count         <= char_n;
      error_count        <= err_n;
      get_next_character <= get_n;
      enable_next_level  <= enable_n;
      correct_pulse      <= correct_n;
      wrong_pulse        <= wrong_n;
      level_done         <= done_n;
      game_over          <= over_n;
    end
  end

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    target_n  = target;
    char_n    = char_count;
    err_n     = error_count;
    get_n     = 1'b0;
    enable_n  = 1'b0;
    correct_n = 1'b0;
    wrong_n   = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          enable_n = 1'b1;
          char_n   = 8'd0;
          err_n    = 8'd0;
          wait_n   = WAIT_LOAD;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        if (wait_cnt != '0) begin
          wait_n = wait_cnt - 1'b1;
        end else begin
          target_n = num_char;
          state_n  = (num_char == 8'd0) ? DONE : TYPING;
        end
      end
      TYPING: begin
        if (scan_valid) begin
          if (scan_code == BREAK_CODE) begin
            state_n = BREAK;
          end else if (scan_code == EXT_CODE) begin
            state_n = EXT;
          end else if (scan_code == LSHIFT || scan_code == RSHIFT) begin
            state_n = TYPING;
          end else if (scan_code == comparison_data) begin
            correct_n = 1'b1;
            char_n    = char_count + 8'd1;
            // The last character ends the level without shifting the sequence.
            if (char_n == target) begin
              state_n = DONE;
            end else begin
              get_n   = 1'b1;
              state_n = ADVANCE;
            end
          end else begin
            wrong_n = 1'b1;
            if (error_count != 8'hFF) err_n = error_count + 8'd1;
`ifdef ERROR_LIMIT_EN
            if (err_n == MAX_ERRORS) state_n = FAIL;
`endif
          end
        end
      end
      BREAK: begin
        if (scan_valid) state_n = TYPING;
      end
      EXT: begin
        if (scan_valid) state_n = (scan_code == BREAK_CODE) ? BREAK : TYPING;
      end
      ADVANCE: begin
        state_n = TYPING;
      end
      FAIL: begin
`ifdef ERROR_LIMIT_EN
        state_n = FAIL;
`else
        state_n = IDLE;
`endif
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    done_n = (state_n == DONE);
`ifdef ERROR_LIMIT_EN
    over_n = (state_n == FAIL);
`else
    over_n = 1'b0;
`endif
  end

`ifndef ERROR_LIMIT_EN
  // Without the limit the error threshold has no effect.
  if (MAX_ERRORS == 8'd0) begin : g_no_error_limit
  end
`endif

endmodule

// File: tb/tb_typing_checker.sv
// tb/tb_typing_checker.sv - directed plus randomized bench for typing_checker
// Build with ERROR_LIMIT_EN defined to exercise the game-over path.
module tb_typing_checker;

  logic       clk = 1'b0;
  logic       reset, start, scan_valid;
  logic [7:0] scan_code, comparison_data, num_char;
  logic       get_next_character, enable_next_level;
  logic [7:0] char_count, error_count;
  logic       correct_pulse, wrong_pulse, level_done, game_over;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ERROR_LIMIT_EN
  localparam int ERR_CAP = 2;
`else
  localparam int ERR_CAP = 100000;
`endif

  always #5 clk = ~clk;

  typing_checker #(.LOAD_WAIT_CYCLES(4), .MAX_ERRORS(8'd3)) dut (
    .clk(clk), .reset(reset), .start(start), .scan_valid(scan_valid),
    .scan_code(scan_code), .comparison_data(comparison_data), .num_char(num_char),
    .get_next_character(get_next_character), .enable_next_level(enable_next_level),
    .char_count(char_count), .error_count(error_count), .correct_pulse(correct_pulse),
    .wrong_pulse(wrong_pulse), .level_done(level_done), .game_over(game_over)
  );

  // Character-sequence provider: a list of levels walked by enable/get pulses.
  int         lvl_len  [5];
  logic [7:0] lvl_data [5][16];
  int         cur_lvl = -1;
  int         pos     = 0;

  always @(posedge clk) begin
    if (enable_next_level) begin
      cur_lvl <= cur_lvl + 1;
      pos     <= 0;
    end else if (get_next_character) begin
      pos <= pos + 1;
    end
  end

  always @* begin
    num_char        = 8'd0;
    comparison_data = 8'd0;
    if (cur_lvl >= 0 && cur_lvl < 5) begin
      num_char = 8'(lvl_len[cur_lvl]);
      if (pos < 16) comparison_data = lvl_data[cur_lvl][pos];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts pulses and checks pulse spacing rules.
  int   n_correct = 0, n_wrong = 0, n_get = 0, n_enable = 0;
  logic p_corr = 1'b0, p_wrong = 1'b0, p_get = 1'b0, p_en = 1'b0;

  always @(negedge clk) begin
    if (correct_pulse)      n_correct++;
    if (wrong_pulse)        n_wrong++;
    if (get_next_character) n_get++;
    if (enable_next_level)  n_enable++;
    if (correct_pulse | wrong_pulse | get_next_character | enable_next_level) begin
      check("get_enable_overlap", 32'(get_next_character & enable_next_level), 32'd0);
      check("pulse_repeat", 32'((correct_pulse & p_corr) | (wrong_pulse & p_wrong) |
                                (get_next_character & p_get) | (enable_next_level & p_en)), 32'd0);
    end
    p_corr  = correct_pulse;
    p_wrong = wrong_pulse;
    p_get   = get_next_character;
    p_en    = enable_next_level;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    idle(gap);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [7:0] rand_letter();
    return 8'($urandom_range(8'h15, 8'h4D));
  endfunction

  // Model of the level in progress: position in the sequence and wrong keys seen.
  int m_char, m_err;

  task automatic random_action(input int lvl);
    logic [7:0] exp_c, b;
    int r;
    exp_c = lvl_data[lvl][m_char];
    r = $urandom_range(0, 5);
    if (r == 3 && m_err >= ERR_CAP) r = 5;
    case (r)
      0, 1, 2: begin
        send(exp_c, 2);
        if ($urandom_range(0, 1) == 1) begin
          send(8'hF0, 2);
          send(exp_c, 2);
        end
        m_char++;
      end
      3: begin
        do b = rand_letter(); while (b == exp_c);
        send(b, 2);
        if ($urandom_range(0, 1) == 1) begin
          send(8'hF0, 2);
          send(b, 2);
        end
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end
      4: begin
        b = ($urandom_range(0, 1) == 1) ? exp_c : rand_letter();
        send(8'hE0, 2);
        send(b, 2);
        send(8'hE0, 2);
        send(8'hF0, 2);
        send(b, 2);
      end
      default: begin
        b = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59;
        send(b, 2);
        send(8'hF0, 2);
        send(b, 2);
      end
    endcase
    check("rand_char_count", 32'(char_count), 32'(m_char));
    check("rand_error_count", 32'(error_count), 32'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int b_corr, b_get, b_wrong, b_en;
  logic [7:0] hello [13];

  initial begin
    lvl_len[0] = 5;
    lvl_data[0][0] = 8'h33; lvl_data[0][1] = 8'h24; lvl_data[0][2] = 8'h4B;
    lvl_data[0][3] = 8'h4B; lvl_data[0][4] = 8'h44;
    lvl_len[1] = 7;
    lvl_data[1][0] = 8'h33; lvl_data[1][1] = 8'h75;
    for (int i = 2; i < 16; i++) lvl_data[1][i] = rand_letter();
    lvl_len[2] = 0;
    lvl_len[3] = 8;
    lvl_len[4] = 8;
    for (int i = 0; i < 16; i++) begin
      lvl_data[3][i] = rand_letter();
      lvl_data[4][i] = rand_letter();
      if (i >= 5) lvl_data[0][i] = 8'h00;
      lvl_data[2][i] = 8'h00;
    end
    hello = '{8'h33, 8'hF0, 8'h33, 8'h24, 8'hF0, 8'h24, 8'h4B, 8'hF0, 8'h4B,
              8'h4B, 8'hF0, 8'h4B, 8'h44};

    reset = 1'b1; start = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
    idle(3);
    check("rst_get", 32'(get_next_character), 32'd0);
    check("rst_enable", 32'(enable_next_level), 32'd0);
    check("rst_char", 32'(char_count), 32'd0);
    check("rst_error", 32'(error_count), 32'd0);
    check("rst_pulses", 32'(correct_pulse | wrong_pulse), 32'd0);
    check("rst_done", 32'(level_done), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    idle(2);

    // Level 0: HELLO with break codes.
    b_en = n_enable;
    pulse_start;
    check("hello_enable_now", 32'(enable_next_level), 32'd1);
    idle(7);
    check("hello_enable_once", 32'(n_enable - b_en), 32'd1);
    b_corr = n_correct; b_get = n_get; b_wrong = n_wrong;
    for (int i = 0; i < 13; i++) send(hello[i], 2);
    check("hello_correct", 32'(n_correct - b_corr), 32'd5);
    check("hello_get", 32'(n_get - b_get), 32'd4);
    check("hello_wrong", 32'(n_wrong - b_wrong), 32'd0);
    check("hello_char", 32'(char_count), 32'd5);
    check("hello_done", 32'(level_done), 32'd1);
    check("hello_error", 32'(error_count), 32'd0);

    // Level 1: wrong key, extended codes, ADVANCE drop, ignored start, random rest.
    pulse_start;
    check("l1_enable_now", 32'(enable_next_level), 32'd1);
    check("l1_char_clear", 32'(char_count), 32'd0);
    check("l1_done_clear", 32'(level_done), 32'd0);
    idle(7);
    b_corr = n_correct; b_get = n_get; b_wrong = n_wrong;
    send(8'h1C, 0);
    check("wrong_pulse", 32'(wrong_pulse), 32'd1);
    check("wrong_no_get", 32'(get_next_character), 32'd0);
    idle(2);
    check("wrong_error", 32'(error_count), 32'd1);
    check("wrong_char", 32'(char_count), 32'd0);
    send(8'h33, 0);
    check("match_pulse", 32'(correct_pulse), 32'd1);
    check("match_get", 32'(get_next_character), 32'd1);
    idle(2);
    check("match_char", 32'(char_count), 32'd1);
    m_char = 1; m_err = 1;
    send(8'hE0, 2); send(8'h75, 2);
    send(8'hE0, 2); send(8'hF0, 2); send(8'h75, 2);
    check("ext_char", 32'(char_count), 32'd1);
    check("ext_error", 32'(error_count), 32'd1);
    check("ext_no_pulse", 32'(n_correct - b_corr), 32'd1);
    send(8'h75, 0);
    send(lvl_data[1][2], 2);
    m_char = 2;
    check("advance_drop_char", 32'(char_count), 32'd2);
    check("advance_drop_pulses", 32'(n_correct - b_corr), 32'd2);
    b_en = n_enable;
    pulse_start;
    idle(2);
    check("start_ignored_typing", 32'(n_enable - b_en), 32'd0);
    while (m_char < 7) begin
      random_action(1);
      if (m_char < 7) check("l1_not_done", 32'(level_done), 32'd0);
    end
    check("l1_done", 32'(level_done), 32'd1);
    check("l1_char", 32'(char_count), 32'd7);
    check("l1_correct", 32'(n_correct - b_corr), 32'd7);
    check("l1_get", 32'(n_get - b_get), 32'd6);
    check("l1_wrong", 32'(n_wrong - b_wrong), 32'(m_err));

    // Level 2: empty level completes straight out of LOAD.
    pulse_start;
    check("l2_error_clear", 32'(error_count), 32'd0);
    check("l2_loading", 32'(level_done), 32'd0);
    idle(7);
    check("l2_done", 32'(level_done), 32'd1);
    check("l2_char", 32'(char_count), 32'd0);

    // Level 3: random typing interrupted by reset.
    pulse_start;
    idle(7);
    m_char = 0; m_err = 0;
    for (int i = 0; i < 5; i++) random_action(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midrst_char", 32'(char_count), 32'd0);
    check("midrst_error", 32'(error_count), 32'd0);
    check("midrst_outs", 32'({get_next_character, enable_next_level, correct_pulse,
                              wrong_pulse, level_done, game_over}), 32'd0);
    b_corr = n_correct;
    send(lvl_data[3][m_char], 2);
    check("idle_key_dropped", 32'(n_correct - b_corr), 32'd0);
    pulse_start;
    check("idle_after_reset", 32'(enable_next_level), 32'd1);
    idle(7);

    // Level 4: error limit or error saturation.
    b_corr = n_correct;
`ifdef ERROR_LIMIT_EN
    send(8'h1C, 2);
    send(8'h1C, 2);
    check("limit_not_yet", 32'(game_over), 32'd0);
    send(8'h1C, 2);
    check("limit_over", 32'(game_over), 32'd1);
    check("limit_error", 32'(error_count), 32'd3);
    b_en = n_enable;
    pulse_start;
    idle(2);
    send(lvl_data[4][0], 2);
    check("fail_start_ignored", 32'(n_enable - b_en), 32'd0);
    check("fail_key_ignored", 32'(n_correct - b_corr), 32'd0);
    check("fail_still_over", 32'(game_over), 32'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("fail_reset", 32'(game_over), 32'd0);
`else
    for (int i = 0; i < 260; i++) begin
      logic [7:0] b;
      do b = rand_letter(); while (b == lvl_data[4][0]);
      send(b, 1);
    end
    check("sat_error", 32'(error_count), 32'd255);
    check("sat_char", 32'(char_count), 32'd0);
    check("sat_no_over", 32'(game_over), 32'd0);
    send(lvl_data[4][0], 2);
    check("sat_then_match", 32'(char_count), 32'd1);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/typing_checker.md
Name: typing_checker

Overview:
- Consumer side of the expected-character stream in the speed-typer game.
- Takes raw PS/2 scan-code bytes from the keyboard receiver and filters out break (F0) and extended (E0) sequences.
- Compares each make code against `comparison_data`. On a match it requests the next character with `get_next_character`; at level end it requests a new level with `enable_next_level`.
- Tracks progress and error counts for the display/score logic.

Parameters:
- LOAD_WAIT_CYCLES, 4, cycles between an `enable_next_level` pulse and sampling `comparison_data`/`num_char`; must be ≥ 3.
- MAX_ERRORS, 8'd10, error limit; used only when ERROR_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  1-cycle pulse: begin the first level / advance to the next level
- scan_valid  input  1  1-cycle strobe: `scan_code` holds a new byte
- scan_code  input  8  raw PS/2 byte
- comparison_data  input  8  expected make code (head of sequence)
- num_char  input  8  characters in the current level
- get_next_character  output  1  1-cycle pulse: shift the sequence by one character
- enable_next_level  output  1  1-cycle pulse: load/advance level
- char_count  output  8  correct characters typed in the current level
- error_count  output  8  wrong keys in the current level, saturates at 255
- correct_pulse  output  1  1-cycle pulse on a matching key
- wrong_pulse  output  1  1-cycle pulse on a mismatching key
- level_done  output  1  high while in DONE
- game_over  output  1  error limit hit (constant 0 without ERROR_LIMIT_EN)

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0.
  - `char_count` = 0, `error_count` = 0.
  - Wait counter = 0.
  - `reset` overrides everything, mid-level included.
- States: IDLE, LOAD, TYPING, BREAK, EXT, ADVANCE, DONE, FAIL.
- IDLE:
  - `start` → pulse `enable_next_level` in the same cycle as the registered output (asserted the cycle after `start` is seen).
  - Clear both counters, load the wait counter, go to LOAD.
- LOAD:
  - Count down LOAD_WAIT_CYCLES.
  - At expiry: latch `num_char` into an internal `target` register.
  - If `target` == 0 → DONE; else → TYPING.
- TYPING, on `scan_valid`:
  - 8'hF0 → BREAK.
  - 8'hE0 → EXT.
  - 8'h12 or 8'h59 (shift) → ignored, stay.
  - `scan_code` == `comparison_data` → pulse `correct_pulse` and `get_next_character`, `char_count`+1.
    - If the new `char_count` == `target` → pulse `level_done` edge, go DONE (no `get_next_character` on the final character).
    - Otherwise → ADVANCE.
  - Any other byte → pulse `wrong_pulse`, `error_count`+1 (saturating), stay in TYPING.
- BREAK: next `scan_valid` byte is consumed silently → TYPING.
- EXT:
  - Next byte 8'hF0 → BREAK.
  - Any other byte consumed → TYPING.
- ADVANCE:
  - Exactly 1 cycle; lets the shift register update `comparison_data`.
  - Then → TYPING.
- Dropped bytes: `scan_valid` in IDLE, LOAD, ADVANCE, DONE or FAIL is dropped; PS/2 byte spacing makes this harmless.
- DONE:
  - `level_done` = 1.
  - `start` → pulse `enable_next_level`, clear counters, → LOAD.
- Output timing: all pulse outputs are registered, never asserted for two consecutive cycles, and `get_next_character` and `enable_next_level` are never asserted together.
- Width and compare rules:
  - `char_count` never exceeds `target`.
  - Comparison is an exact 8-bit equality.
- `start` in TYPING, BREAK, EXT or ADVANCE is ignored.

Optional Feature:
- Macro: ERROR_LIMIT_EN.
- Defined: when a wrong key makes `error_count` == MAX_ERRORS, go to FAIL instead of staying in TYPING.
  - In FAIL: `game_over` = 1, all keys are ignored, and `start` is ignored.
  - Only `reset` exits FAIL.
- Undefined: FAIL state absent, `game_over` tied 0, errors only counted.

Test Plan:
- Reset, `start`; bench model returns `num_char`=5 and the sequence 33 24 4B 4B 44 (HELLO) → exactly one `enable_next_level` pulse. Then type 33,F0,33,24,F0,24,4B,F0,4B,4B,F0,4B,44 → `correct_pulse` ×5, `get_next_character` ×4, `char_count`=5, `level_done`=1, `error_count`=0.
- In TYPING with expected 8'h33, send 8'h1C → `wrong_pulse`, `error_count`=1, `char_count`=0, no `get_next_character`. Then send 8'h33 → match.
- Send E0,75 then E0,F0,75 with expected 8'h75 → no pulses, no count change.
- From DONE, pulse `start` → `enable_next_level` one cycle later, counters cleared, new `target` = `num_char` (7) latched after LOAD_WAIT_CYCLES.
- `scan_valid` asserted in the cycle after a correct key (ADVANCE) → byte dropped; `reset` asserted mid-level → all outputs 0 and state IDLE next cycle.
- With ERROR_LIMIT_EN, MAX_ERRORS=3: three wrong keys → `game_over`=1. Subsequent `start` and keys have no effect until `reset`.
